softex_max_rescale_queue: RTL

- Sits directly downstream of the global max/min tracker in the softmax datapath.
- Captures every running-extremum update (new_flg / cur / new) and converts it into a rescale request (old_max, new_max) for the denominator accumulator, which applies exp(old - new).
- Buffers requests in a small FIFO so the accumulator can stall without back-pressuring the tracker.
- When the FIFO is full, merges the incoming update into the tail entry, because exp(a-b)·exp(b-c) = exp(a-c).

---
 rtl/softex_max_rescale_queue_pkg.sv | 70 +++++++
 rtl/softex_max_rescale_queue_merge_fifo.sv | 101 ++++++++++
 rtl/softex_max_rescale_queue.sv | 109 ++++++++++
 3 files changed

// File: rtl/softex_max_rescale_queue_pkg.sv
// ----------------------------------------------------------------------------
// softex_max_rescale_queue_pkg
//
// Shared types and helpers for the softmax max/min rescale queue:
//   - fp_format_e / fp_width(): floating-point formats and their bit widths
//   - pos_infty() / neg_infty(): infinity encodings, zero-extended to 64 bits
//   - min_max_mode_t: MAX or MIN tracking mode
//   - FPFORMAT_IN: default format of the extremum values
//   - rescale_req_t: one rescale request {old_max, new_max} in FPFORMAT_IN
// ----------------------------------------------------------------------------
package softex_max_rescale_queue_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    typedef enum logic {
        MAX = 1'b0,
        MIN = 1'b1
    } min_max_mode_t;

    localparam fp_format_e FPFORMAT_IN = FP16ALT;

    function automatic int unsigned exp_bits(input fp_format_e fmt);
        case (fmt)
            FP32:    return 8;
            FP64:    return 11;
            FP16:    return 5;
            FP8:     return 5;
            FP16ALT: return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(input fp_format_e fmt);
        case (fmt)
            FP32:    return 23;
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 23;
        endcase
    endfunction

    function automatic int unsigned fp_width(input fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

    // Exponent all ones, mantissa zero, sign clear.
    function automatic logic [63:0] pos_infty(input fp_format_e fmt);
        return ((64'd1 << exp_bits(fmt)) - 64'd1) << man_bits(fmt);
    endfunction

    function automatic logic [63:0] neg_infty(input fp_format_e fmt);
        return pos_infty(fmt) | (64'd1 << (fp_width(fmt) - 1));
    endfunction

    localparam int unsigned WIDTH_IN = fp_width(FPFORMAT_IN);

    typedef struct packed {
        logic [WIDTH_IN-1:0] old_max;
        logic [WIDTH_IN-1:0] new_max;
    } rescale_req_t;

endpackage

// File: rtl/softex_max_rescale_queue_merge_fifo.sv
// ----------------------------------------------------------------------------
// softex_merge_fifo
//
// Small synchronous FIFO with a masked tail-overwrite port, so an incoming
// item can be folded into the most recently written entry instead of taking
// a new slot. DEPTH need not be a power of two.
//
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset
//   clear_i           synchronous flush (same effect as reset)
//   push_i            write data_i at the tail (accepted if not full, or if
//                     a pop happens in the same cycle)
//   tail_we_i         overwrite the bits of the last written entry selected by
//                     tail_mask_i with data_i (ignored when a push is accepted)
//   tail_mask_i       bit mask for the tail overwrite
//   data_i            write data for push and tail overwrite
//   pop_i             advance the head (ignored when empty)
//   head_o            head entry
//   valid_o           FIFO non-empty
//   full_o            FIFO holds DEPTH entries
// ----------------------------------------------------------------------------
module softex_merge_fifo #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic                  tail_we_i,
    input  logic [DATA_WIDTH-1:0] tail_mask_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  valid_o,
    output logic                  full_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      tail_ptr;
    logic [OCC_W-1:0]      occ;
    logic                  empty;
    logic                  do_push;
    logic                  do_pop;
    logic                  do_tail;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    // The tail is the slot just behind the write pointer.
    assign tail_ptr = (wr_ptr == '0) ? LAST_PTR : wr_ptr - 1'b1;
    assign empty    = (occ == '0);
    assign full_o   = (occ == FULL_OCC);
    assign valid_o  = ~empty;
    assign head_o   = mem[rd_ptr];

    assign do_pop  = pop_i & ~empty;
    // When full, a same-cycle pop frees the head slot, which is exactly the
    // slot the write pointer lands on.
    assign do_push = push_i & (~full_o | do_pop);
    assign do_tail = tail_we_i & ~empty & ~do_push;

    always_ff @(posedge clk_i) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!rst_ni || clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            // NOTE: storage is cleared too (only DEPTH entries) so the data
            // outputs read zero after reset or clear, not stale contents.
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wrap_inc(wr_ptr);
            end else if (do_tail) begin
                mem[tail_ptr] <= (mem[tail_ptr] & ~tail_mask_i) | (data_i & tail_mask_i);
            end
            if (do_pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/softex_max_rescale_queue.sv
// ----------------------------------------------------------------------------
// softex_max_rescale_queue
//
// Turns running-extremum updates from the max/min tracker into rescale
// requests (old, new) for the denominator accumulator, buffered in a small
// FIFO. When the FIFO is full and nothing drains, a new update is merged into
// the tail entry: exp(a-b)*exp(b-c) = exp(a-c), so keeping the tail's old value
// and replacing its new value is exact.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   clear_i              synchronous clear: empties FIFO, zeroes counter
//   enable_i             gates push, pop and count
//   operation_i          MAX or MIN; selects the "accumulator empty" sentinel
//   new_flg_i            tracker committed a new extremum this cycle
//   cur_max_i            extremum before the update
//   new_max_i            extremum after the update
//   rescale_valid_o      head request valid
//   rescale_ready_i      accumulator accepts the head request
//   rescale_old_o        head old value
//   rescale_new_o        head new value
//   pending_o            FIFO non-empty
//   merged_o             this cycle's update is merged into the tail
//   update_cnt_o         accepted updates, saturating
// ----------------------------------------------------------------------------
module softex_max_rescale_queue
    import softex_max_rescale_queue_pkg::*;
#(
    parameter fp_format_e  FPFORMAT  = FPFORMAT_IN,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned CNT_WIDTH = 16,
    localparam int unsigned WIDTH    = fp_width(FPFORMAT)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  min_max_mode_t        operation_i,
    input  logic                 new_flg_i,
    input  logic [WIDTH-1:0]     cur_max_i,
    input  logic [WIDTH-1:0]     new_max_i,
    output logic                 rescale_valid_o,
    input  logic                 rescale_ready_i,
    output logic [WIDTH-1:0]     rescale_old_o,
    output logic [WIDTH-1:0]     rescale_new_o,
    output logic                 pending_o,
    output logic                 merged_o,
    output logic [CNT_WIDTH-1:0] update_cnt_o
);

    localparam logic [WIDTH-1:0] NEG_INF = WIDTH'(neg_infty(FPFORMAT));
    localparam logic [WIDTH-1:0] POS_INF = WIDTH'(pos_infty(FPFORMAT));
    // Merge overwrites only the new-value half of the tail entry.
    localparam logic [2*WIDTH-1:0] NEW_MASK = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};

    logic                 ev;
    logic                 skip;
    logic                 push_req;
    logic                 pop;
    logic                 merge;
    logic                 valid;
    logic                 full;
    logic [WIDTH-1:0]     sentinel;
    logic [2*WIDTH-1:0]   head;
    logic [CNT_WIDTH-1:0] cnt;

    // A current extremum still at its initial infinity means the accumulator
    // holds nothing yet, so there is nothing to rescale.
    assign sentinel = (operation_i == MIN) ? POS_INF : NEG_INF;
    assign ev       = enable_i & new_flg_i;
    assign skip     = (cur_max_i == sentinel);
    assign push_req = ev & ~skip;
    assign pop      = enable_i & valid & rescale_ready_i;
    // Reset and clear win over everything, so no merge is reported then.
    assign merge    = rst_ni & ~clear_i & push_req & full & ~pop;

    softex_merge_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (2 * WIDTH)
    ) i_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .push_i      (push_req & ~merge),
        .tail_we_i   (merge),
        .tail_mask_i (NEW_MASK),
        .data_i      ({cur_max_i, new_max_i}),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (valid),
        .full_o      (full)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            cnt <= '0;
        end else if (ev && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign rescale_valid_o = valid;
    assign pending_o       = valid;
    assign rescale_old_o   = head[2*WIDTH-1:WIDTH];
    assign rescale_new_o   = head[WIDTH-1:0];
    assign merged_o        = merge;
    assign update_cnt_o    = cnt;

endmodule
